// File: rtl/pwl_rsqrt_cfg.sv
// Piecewise-linear 1/sqrt(x) with one runtime-loadable segment per input octave, 4-stage compacting pipeline.
// Optional build macro PWL_EPS_ADD_EN adds a saturating epsilon to the input before segment lookup.
module pwl_rsqrt_cfg #(
  parameter int IN_W      = 16,
  parameter int IN_FRAC   = 11,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 11,
  parameter int COEF_FRAC = 14,
  parameter int EPS       = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [IN_W-1:0]          i_variance,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [OUT_W-1:0]         o_result,
  output logic                     o_sat,
  output logic                     o_zero,
  input  logic                     i_cfg_we,
  input  logic [$clog2(IN_W)-1:0]  i_cfg_addr,
  input  logic [OUT_W-1:0]         i_cfg_slope,
  input  logic [OUT_W-1:0]         i_cfg_icpt
);

  localparam int AW = $clog2(IN_W);
  localparam int PW = OUT_W + IN_W + 1;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] RND  = {{(SW-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (IN_FRAC > IN_W || OUT_FRAC > OUT_W || COEF_FRAC < 1 || EPS < 0) begin : g_bad_cfg
    $error("pwl_rsqrt_cfg: inconsistent format parameters");
  end

  function automatic logic [AW-1:0] lod(input logic [IN_W-1:0] x);
    lod = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (x[i]) lod = AW'(i);
    end
  endfunction

  logic signed [OUT_W-1:0] slope_r [IN_W];
  logic signed [OUT_W-1:0] icpt_r  [IN_W];

  logic                    v1_r, v2_r, v3_r;
  logic [IN_W-1:0]         x1_r, x2_r;
  logic [AW-1:0]           p1_r;
  logic                    z1_r, z2_r, z3_r;
  logic signed [OUT_W-1:0] a2_r, b2_r, b3_r;
  logic signed [PW-1:0]    prod3_r;

  logic                    stall_s, acc_s, ld1_s, ld2_s, ld3_s, ld4_s;
  logic [IN_W-1:0]         xin_s;
  logic                    zin_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [SW-1:0]    sum_s;
  logic [OUT_W-1:0]        y_s;
  logic                    sat_s;

  // Each stage moves forward when the next one is empty or itself moving, so bubbles close up under stall.
  assign stall_s = o_valid & ~i_ready;
  assign o_ready = i_en & ~stall_s;
  assign acc_s   = i_valid & o_ready;
  assign ld4_s   = i_en & (~o_valid | i_ready);
  assign ld3_s   = i_en & (~v3_r | ld4_s);
  assign ld2_s   = i_en & (~v2_r | ld3_s);
  assign ld1_s   = i_en & (~v1_r | ld2_s);

  assign prod_s = PW'(a2_r) * $signed(PW'({1'b0, x2_r}));
  assign sum_s  = SW'(b3_r) + ((SW'(prod3_r) + RND) >>> COEF_FRAC);

  // Input conditioning: optional saturating epsilon, zero detect.
`ifdef PWL_EPS_ADD_EN
  localparam logic [IN_W:0] EPS_W = (IN_W + 1)'(EPS);
  logic [IN_W:0] xeps_s;
  always_comb begin
    xeps_s = {1'b0, i_variance} + EPS_W;
    zin_s  = 1'b0;
    if (xeps_s[IN_W]) begin
      xin_s = '1;
    end else begin
      xin_s = xeps_s[IN_W-1:0];
    end
  end
`else
  always_comb begin
    xin_s = i_variance;
    zin_s = (i_variance == '0);
  end
`endif

  // Clamp the rounded sum into the signed output range.
  always_comb begin
    y_s   = sum_s[OUT_W-1:0];
    sat_s = 1'b0;
    if (sum_s > MAXV) begin
      y_s   = MAXV[OUT_W-1:0];
      sat_s = 1'b1;
    end else if (sum_s < MINV) begin
      y_s   = MINV[OUT_W-1:0];
      sat_s = 1'b1;
    end else begin
      y_s   = sum_s[OUT_W-1:0];
      sat_s = 1'b0;
    end
  end

  // Coefficient table: writes land at the edge, so a same-cycle S2 read still sees the old entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < IN_W; i++) begin
        slope_r[i] <= '0;
        icpt_r[i]  <= '0;
      end
    end else if (i_cfg_we && (int'(i_cfg_addr) < IN_W)) begin
      slope_r[i_cfg_addr] <= $signed(i_cfg_slope);
      icpt_r[i_cfg_addr]  <= $signed(i_cfg_icpt);
    end
  end

  // Pipeline stages S1..S4; payload only captured when a valid sample moves in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      v3_r     <= 1'b0;
      o_valid  <= 1'b0;
      x1_r     <= '0;
      x2_r     <= '0;
      p1_r     <= '0;
      z1_r     <= 1'b0;
      z2_r     <= 1'b0;
      z3_r     <= 1'b0;
      a2_r     <= '0;
      b2_r     <= '0;
      b3_r     <= '0;
      prod3_r  <= '0;
      o_result <= '0;
      o_sat    <= 1'b0;
      o_zero   <= 1'b0;
    end else begin
      if (ld1_s) begin
        v1_r <= acc_s;
        if (acc_s) begin
          x1_r <= xin_s;
          p1_r <= lod(xin_s);
          z1_r <= zin_s;
        end
      end
      if (ld2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          a2_r <= slope_r[p1_r];
          b2_r <= icpt_r[p1_r];
          x2_r <= x1_r;
          z2_r <= z1_r;
        end
      end
      if (ld3_s) begin
        v3_r <= v2_r;
        if (v2_r) begin
          prod3_r <= prod_s;
          b3_r    <= b2_r;
          z3_r    <= z2_r;
        end
      end
      if (ld4_s) begin
        o_valid <= v3_r;
        if (v3_r) begin
          if (z3_r) begin
            o_result <= MAXV[OUT_W-1:0];
            o_sat    <= 1'b0;
            o_zero   <= 1'b1;
          end else begin
            o_result <= y_s;
            o_sat    <= sat_s;
            o_zero   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/pwl_rsqrt_cfg.md
Name: pwl_rsqrt_cfg

Overview:
Parametrised successor to the fixed LayerNorm PWL inverse-sqrt unit. Maps an unsigned fixed-point variance to a signed fixed-point 1/sqrt(x) using a piecewise-linear table with one segment per input octave. The segment for an input is selected by the position of its leading one.
Adds three things to the fixed unit:
- runtime-loadable slope/intercept table
- valid/ready backpressure
- saturation and zero-input flags
Sits between the variance accumulator and the normalise multiplier in the LayerNorm datapath.

Parameters:
IN_W, 16, input width (unsigned, UQ(IN_W-IN_FRAC).IN_FRAC)
IN_FRAC, 11, input fraction bits
OUT_W, 16, output width (signed two's complement)
OUT_FRAC, 11, output fraction bits
COEF_FRAC, 14, slope fraction bits; slope is signed OUT_W bits
EPS, 1, epsilon in input LSBs (used only with optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  global enable; 0 freezes whole pipeline
i_valid  in  1  input sample valid
o_ready  out  1  unit can accept sample this cycle
i_variance  in  IN_W  input sample
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_result  out  OUT_W  approximated 1/sqrt(x), signed
o_sat  out  1  result was clamped (qualified by o_valid)
o_zero  out  1  input was zero (qualified by o_valid)
i_cfg_we  in  1  table write strobe
i_cfg_addr  in  $clog2(IN_W)  segment index (0..IN_W-1)
i_cfg_slope  in  OUT_W  signed slope, Q.COEF_FRAC
i_cfg_icpt  in  OUT_W  signed intercept, output format

Behaviour:
- Reset (async on i_rst_n low, released synchronously to i_clk):
  - o_valid, o_result, o_sat, o_zero = 0; all pipeline valid bits = 0.
  - All IN_W table entries (slope, icpt) = 0.
  - o_ready = 1 once out of reset with i_en=1.
- Pipeline has 4 stages, each with its own valid bit. Latency is 4 accepted cycles, input transfer to o_valid, with no stall. Throughput 1/cycle.
  - S1: register x; LOD gives p = index of most significant set bit; zero flag = (x==0).
  - S2: register table[p] (slope a, intercept b).
  - S3: register prod = a * x, signed OUT_W x unsigned IN_W, full width OUT_W+IN_W+1.
  - S4: y = b + ((prod + 2^(COEF_FRAC-1)) >>> COEF_FRAC), round half-up.
    - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; o_sat=1 if clamped.
    - Zero input forces o_result = 2^(OUT_W-1)-1, o_zero=1, o_sat=0.
- Handshake:
  - Input transfer when i_valid & o_ready.
  - Output transfer when o_valid & i_ready.
  - Stall when o_valid & !i_ready: all stages hold; o_result/o_sat/o_zero stable.
  - o_ready = i_en & !(stall).
  - Bubbles may be filled during a stall only if stage is empty (compacting pipeline): a stage advances if the next stage is empty or advancing.
- i_en=0: no stage advances, o_ready=0, outputs held; o_valid unchanged.
- Table writes:
  - Accepted any cycle, independent of i_en and stalls.
  - A write at cycle t is visible to S2 reads at t+1 or later. A same-cycle read of the same address returns the old value.
  - i_cfg_addr >= IN_W: write ignored.
- Reset mid-operation drops all in-flight samples; no partial output.

Optional Feature:
PWL_EPS_ADD_EN:
- Defined: S1 uses x' = min(i_variance + EPS, 2^IN_W-1), a saturating add; LOD and multiply use x'; o_zero is never asserted.
- Undefined: x' = i_variance; zero handling as above.
- Latency is the same in both cases.

Test Plan:
- Constant-table octave test: load slope=0, icpt=p*256 for all p; send 0x1000 (2.0) -> o_result=0x0C00 exactly 4 cycles later, o_sat=0.
- Linear segment: table[11] = slope 0xE000 (-0.5), icpt 0x0C00 (1.5); send 0x0C00 (1.5) -> o_result=0x0600 (0.75).
- Saturation/zero: table[15] = slope 0x3FFF, icpt 0x7FFF; send 0xFFFF -> o_result=0x7FFF, o_sat=1. Send 0x0000 -> o_result=0x7FFF, o_zero=1 (macro undefined).
- Backpressure: 10-sample burst (0.5..5.0) with i_ready low cycles 3-7 -> 10 results, in order, none lost or duplicated; o_result stable while stalled; o_ready low during stall once the pipeline is full.
- Burst/gap/burst as in the fixed unit, with a write to table[p] in mid-stream -> samples whose S2 is at or after t+1 use the new coefficients, earlier ones the old.
- Async reset with 3 samples in flight -> o_valid falls without a clock edge; no result emerges after release; table reads return 0 (o_result=0).
